// File: rtl/ip_unit_pkg.sv
// Shared definitions for the instruction pointer unit: default word width and
// the update-mode encoding driven by the decoder.
package ip_unit_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IP_MODE_REL  = 2'b00,
    IP_MODE_JMP  = 2'b01,
    IP_MODE_CALL = 2'b10,
    IP_MODE_RET  = 2'b11
  } ip_mode_e;

  localparam logic [1:0] IP_MODE_REL_C  = IP_MODE_REL;
  localparam logic [1:0] IP_MODE_JMP_C  = IP_MODE_JMP;
  localparam logic [1:0] IP_MODE_CALL_C = IP_MODE_CALL;
  localparam logic [1:0] IP_MODE_RET_C  = IP_MODE_RET;

endpackage

// File: rtl/ip_unit_if.sv
// Control/fetch-side bundle of the instruction pointer unit.
// master = decoder/control side, slave = the ip_unit itself.
interface ip_unit_if #(
  parameter int WORD_SIZE   = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                 advance;
  logic [1:0]           mode;
  logic [WORD_SIZE-1:0] adj;
  logic [WORD_SIZE-1:0] target;
  logic                 restart;
  logic                 clear_flags;
  logic [WORD_SIZE-1:0] out;
  logic [WORD_SIZE-1:0] ret_top;
  logic [DEPTH_W-1:0]   depth;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output advance, mode, adj, target, restart, clear_flags,
    input  out, ret_top, depth, overflow, underflow
  );

  modport slave (
    input  advance, mode, adj, target, restart, clear_flags,
    output out, ret_top, depth, overflow, underflow
  );
endinterface

// File: rtl/ip_unit_return_stack.sv
// Circular return-address stack: when full, a push overwrites the oldest
// entry and reports it through overflow_evt for one cycle.
module ip_return_stack #(
  parameter int WORD_SIZE   = 16,
  parameter int STACK_DEPTH = 8,
  localparam int PTR_W      = $clog2(STACK_DEPTH),
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] push_data,
  output logic [WORD_SIZE-1:0] top,
  output logic [DEPTH_W-1:0]   depth,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow_evt
);

  logic [WORD_SIZE-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]     ptr_reg, ptr_next;
  logic [DEPTH_W-1:0]   depth_reg, depth_next;
  logic [PTR_W-1:0]     ptr_inc, ptr_dec;

  // Depth need not be a power of two, so both wraps are explicit.
  assign ptr_inc = (ptr_reg == PTR_W'(STACK_DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
  assign ptr_dec = (ptr_reg == '0) ? PTR_W'(STACK_DEPTH - 1) : ptr_reg - 1'b1;

  assign full         = (depth_reg == DEPTH_W'(STACK_DEPTH));
  assign empty        = (depth_reg == '0);
  assign depth        = depth_reg;
  assign top          = empty ? '0 : mem[ptr_dec];
  assign overflow_evt = push && !clear && full;

  always_comb begin
    ptr_next   = ptr_reg;
    depth_next = depth_reg;
    if (clear) begin
      ptr_next   = '0;
      depth_next = '0;
    end else if (push) begin
      ptr_next = ptr_inc;
      if (!full) begin
        depth_next = depth_reg + 1'b1;
      end
    end else if (pop && !empty) begin
      ptr_next   = ptr_dec;
      depth_next = depth_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg   <= '0;
      depth_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      depth_reg <= depth_next;
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/ip_unit.sv
// Instruction pointer with relative/jump/call/return updates, a circular
// return stack and sticky overflow/underflow flags.
module ip_unit
  import ip_unit_pkg::*;
#(
  parameter int                   WORD_SIZE    = ip_unit_pkg::WORD_SIZE,
  parameter int                   STACK_DEPTH  = 8,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
  input logic       clk,
  input logic       reset_n,
  ip_unit_if.slave  bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [WORD_SIZE-1:0] out_reg, out_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;

  logic                 stk_clear, stk_push, stk_pop;
  logic [WORD_SIZE-1:0] stk_push_data, stk_top;
  logic [DEPTH_W-1:0]   stk_depth;
  logic                 stk_full, stk_empty, stk_overflow_evt;

  logic [WORD_SIZE-1:0] step_addr;
  ip_mode_e             mode;

  assign step_addr = out_reg + bus.adj;
  assign mode      = ip_mode_e'(bus.mode);

  ip_return_stack #(
    .WORD_SIZE   (WORD_SIZE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (stk_clear),
    .push         (stk_push),
    .pop          (stk_pop),
    .push_data    (stk_push_data),
    .top          (stk_top),
    .depth        (stk_depth),
    .full         (stk_full),
    .empty        (stk_empty),
    .overflow_evt (stk_overflow_evt)
  );

  always_comb begin
    out_next       = out_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    stk_clear      = 1'b0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    stk_push_data  = step_addr;

    if (bus.restart) begin
      out_next       = RESET_VECTOR;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
      stk_clear      = 1'b1;
    end else begin
      // Clear first so a same-cycle set below takes precedence.
      if (bus.clear_flags) begin
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
      end
      if (bus.advance) begin
        case (mode)
          IP_MODE_REL: out_next = step_addr;
          IP_MODE_JMP: out_next = bus.target;
          IP_MODE_CALL: begin
            stk_push = 1'b1;
            out_next = bus.target;
            if (stk_full) begin
              overflow_next = 1'b1;
            end
          end
          IP_MODE_RET: begin
            if (stk_empty) begin
              out_next       = step_addr;
              underflow_next = 1'b1;
            end else begin
              stk_pop  = 1'b1;
              out_next = stk_top;
            end
          end
          default: out_next = out_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg       <= RESET_VECTOR;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      out_reg       <= out_next;
      overflow_reg  <= overflow_next || stk_overflow_evt;
      underflow_reg <= underflow_next;
    end
  end

  assign bus.out       = out_reg;
  assign bus.ret_top   = stk_top;
  assign bus.depth     = stk_depth;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;

endmodule

// File: doc/ip_unit.md
Name: ip_unit

Overview:
- Parametrised successor to the basic instruction pointer.
- Holds the program counter and supports four update modes: relative step, absolute jump, call and return.
- Contains an internal return-address stack of configurable depth, with sticky overflow/underflow flags.
- Sits between the decoder/control unit (which drives mode, adj and target) and instruction fetch (which consumes out).

Parameters:
- WORD_SIZE, 16, address/word width; taken from the shared parameters include.
- STACK_DEPTH, 8, number of return-stack entries; must be 2 or more.
- RESET_VECTOR, 0, value loaded into out by reset and by restart.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- advance  input  1  when high, apply mode this cycle; when low, hold all state.
- mode  input  2  00 REL, 01 JMP, 10 CALL, 11 RET.
- adj  input  WORD_SIZE  signed offset; next-instruction step for REL, CALL and RET fall-through.
- target  input  WORD_SIZE  absolute destination for JMP and CALL.
- restart  input  1  synchronous soft reset; replaces the old dedicated reset clock.
- clear_flags  input  1  synchronous clear of the sticky flags.
- out  output  WORD_SIZE  current instruction address.
- ret_top  output  WORD_SIZE  combinational top-of-stack; 0 when the stack is empty.
- depth  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky; set when a CALL overwrites the oldest entry.
- underflow  output  1  sticky; set when a RET is issued with an empty stack.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out = RESET_VECTOR; depth = 0; overflow = 0; underflow = 0; stack pointer = 0.
  - Stack contents are don't-care.
- Priority per edge: restart > advance. clear_flags is evaluated independently.
- restart:
  - out <= RESET_VECTOR; depth <= 0; flags <= 0.
  - advance is ignored that cycle.
- advance with mode REL: out <= out + adj, modulo 2^WORD_SIZE. Wrap is silent, both directions.
- advance with mode JMP: out <= target.
- advance with mode CALL:
  - Push (out + adj) mod 2^WORD_SIZE, then out <= target.
  - If depth == STACK_DEPTH: the stack is circular and the oldest entry is overwritten. depth stays at STACK_DEPTH and overflow <= 1.
- advance with mode RET:
  - If depth > 0: out <= top entry and depth decrements.
  - If depth == 0: out <= out + adj (fall-through) and underflow <= 1.
- Latency:
  - All updates are visible on out/depth one cycle after the sampling edge.
  - ret_top reflects the new top in that same cycle.
- clear_flags: clears both flags at the edge. If an event in the same cycle would set a flag, the set wins (flag reads 1 afterwards).
- advance low: out, stack, depth and flags all hold. adj, target and mode are don't-care.
- Stack organisation:
  - Circular buffer with a write pointer of clog2(STACK_DEPTH) bits.
  - Push writes at ptr and increments ptr. Pop decrements ptr and reads ptr-1.
  - Pointer wraps modulo STACK_DEPTH; STACK_DEPTH need not be a power of two, so wrap is explicit.
- Reset mid-operation: async assertion takes effect immediately regardless of clk. No partially updated state is allowed.

Decomposition:
- Shared parameters include: WORD_SIZE, plus mode constants IP_MODE_REL=2'b00, IP_MODE_JMP=2'b01, IP_MODE_CALL=2'b10, IP_MODE_RET=2'b11.
- Sub-module ip_return_stack owns the circular storage, pointer, depth counter and overflow detection.
  - Interface: push, pop, push_data, top, depth, full, empty.
  - Same clk/reset_n.
- ip_unit owns out, the mode decode, the flags and the restart handling.

Test Plan:
- Reset then REL: reset_n low→high; advance, REL, adj=+2, three cycles → out = 0, 2, 4, 6; depth = 0; flags = 0.
- Negative wrap: out=0x0000, REL adj=-1 → out=0xFFFF. Then JMP target=0x1234 → out=0x1234.
- CALL/RET round trip:
  - out=0x0010, CALL adj=2 target=0x0100 → out=0x0100, depth=1, ret_top=0x0012.
  - Then RET → out=0x0012, depth=0.
- Overflow with STACK_DEPTH=8:
  - Nine CALLs from distinct addresses → depth=8, overflow=1.
  - Eight RETs return the 9th..2nd return addresses.
  - A ninth RET → underflow=1, out=out+adj.
- Simultaneous events:
  - RET on empty stack with clear_flags=1 → underflow=1.
  - restart plus advance CALL → out=RESET_VECTOR, depth=0, flags=0.
- Async reset mid-stream: pull reset_n low between clock edges with depth=3 → out=RESET_VECTOR and depth=0 before the next edge.
